// File: rtl/usb_stream_in_ep.sv
// usb_stream_in_ep: bulk IN endpoint packing a byte stream into USB IN packets.
// Full packets are committed at once; short packets and ZLPs are flushed after SOF timeouts.
module usb_stream_in_ep #(
    parameter int MAX_PKT    = 64,
    parameter int FIFO_DEPTH = 128,
    parameter int FLUSH_SOFS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          in_ep_req,
    input  logic                          in_ep_grant,
    input  logic                          in_ep_data_free,
    output logic                          in_ep_data_put,
    output logic [7:0]                    in_ep_data,
    output logic                          in_ep_data_done,
    output logic                          in_ep_stall,
    input  logic                          in_ep_acked,
    input  logic                          sof_valid,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(MAX_PKT + 1);
    localparam int TW = $clog2(FLUSH_SOFS + 1);
    localparam logic [AW:0]   LVL_MAX  = (AW + 1)'(MAX_PKT);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LEN_MAX  = PW'(MAX_PKT);
    localparam logic [TW-1:0] T_FLUSH  = TW'(FLUSH_SOFS);

    typedef enum logic [1:0] {IDLE, REQ, FILL, WAIT_ACK} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] len, remaining, len_nxt;
    logic [TW-1:0] timer;
    logic          zlp_pending, flush, push, commit, ack;

    assign in_ready = fifo_level != LVL_FULL;
    assign push     = in_valid && in_ready;
    assign flush    = timer == T_FLUSH;
    assign ack      = state == WAIT_ACK && in_ep_acked;
    assign commit   = state == IDLE && (fifo_level >= LVL_MAX || (flush && (fifo_level != '0 || zlp_pending)));
    // Below MAX_PKT the level always fits the length field; a ZLP commits with level 0.
    assign len_nxt  = fifo_level >= LVL_MAX ? LEN_MAX : PW'(fifo_level);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     state_nxt = commit ? REQ : IDLE;
            REQ:      state_nxt = in_ep_grant ? FILL : REQ;
            FILL:     state_nxt = remaining == '0 ? WAIT_ACK : FILL;
            WAIT_ACK: state_nxt = in_ep_acked ? IDLE : WAIT_ACK;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ep_req       = state != IDLE;
        in_ep_data_put  = state == FILL && in_ep_grant && in_ep_data_free && remaining != '0;
        in_ep_data_done = state == FILL && remaining == '0;
        in_ep_data      = in_ep_data_put ? mem[rd_ptr] : 8'h00;
        in_ep_stall     = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            timer       <= '0;
            zlp_pending <= 1'b0;
            len         <= '0;
            remaining   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (in_ep_data_put)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level  <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, in_ep_data_put};
            timer       <= (push || commit || ack) ? '0 : (sof_valid && !flush) ? timer + 1'b1 : timer;
            zlp_pending <= commit ? 1'b0 : (ack && len == LEN_MAX) ? 1'b1 : zlp_pending;
            if (commit) begin
                len       <= len_nxt;
                remaining <= len_nxt;
            end else if (in_ep_data_put) begin
                remaining <= remaining - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_usb_stream_in_ep.sv
// tb_usb_stream_in_ep: directed steps with random data, checked against a byte-queue packet model.
module tb_usb_stream_in_ep;
    localparam int MAX_PKT = 64;
    localparam int DEPTH   = 128;

    logic       clk = 0, reset = 1;
    logic       in_ep_req, in_ep_grant = 0, in_ep_data_free = 0, in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done, in_ep_stall, in_ep_acked = 0, sof_valid = 0;
    logic [7:0] in_data = 0;
    logic       in_valid = 0, in_ready;
    logic [7:0] fifo_level;

    usb_stream_in_ep #(.MAX_PKT(MAX_PKT), .FIFO_DEPTH(DEPTH), .FLUSH_SOFS(2)) dut (
        .clk(clk), .reset(reset),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant), .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked), .sof_valid(sof_valid),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    logic [7:0] src_q[$], exp_q[$];
    int pkt_lens[$];
    int vectors = 0, miscompares = 0;
    int model_level = 0, cur_len = 0, prev_len = -1, cyc_n = 0;
    int last_put_cyc = -10, last_done_cyc = -10, puts_total = 0;
    int free_mode = 0, ack_wait = -1, sof_now = 0, sof_period = 0;
    bit grant_en = 1, auto_ack = 1;
    int k, req_low, puts0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, update the model, then drive the next inputs after the edge.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (!reset) begin
            chk("level", fifo_level, model_level);
            chk("in_ready", in_ready, model_level != DEPTH);
            chk("stall", in_ep_stall, 0);
            if (in_ep_data_put) begin
                chk("put_gated", in_ep_grant && in_ep_data_free && in_ep_req, 1);
                if (exp_q.size() == 0)
                    chk("put_underflow", 1, 0);
                else
                    chk("put_data", in_ep_data, exp_q.pop_front());
                cur_len++;
                last_put_cyc = cyc_n;
                puts_total++;
                model_level--;
            end
            if (in_ep_data_done) begin
                chk("done_timing", cur_len == 0 || last_put_cyc == cyc_n - 1, 1);
                chk("done_width", last_done_cyc != cyc_n - 1, 1);
                chk("pkt_len_max", cur_len <= MAX_PKT, 1);
                if (cur_len == 0)
                    chk("zlp_after_max", prev_len, MAX_PKT);
                pkt_lens.push_back(cur_len);
                prev_len = cur_len;
                cur_len = 0;
                last_done_cyc = cyc_n;
                if (auto_ack)
                    ack_wait = $urandom_range(0, 3);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(src_q.pop_front());
                model_level++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = src_q.size() > 0;
        in_data = in_valid ? src_q[0] : 8'h00;
        in_ep_grant = grant_en;
        in_ep_data_free = free_mode == 0 ? 1'b1 : (cyc_n % 2 == 0);
        in_ep_acked = 0;
        if (ack_wait == 0) begin
            in_ep_acked = 1;
            ack_wait = -1;
        end else if (ack_wait > 0) begin
            ack_wait--;
        end
        sof_valid = 0;
        if (sof_now > 0) begin
            sof_valid = 1;
            sof_now--;
        end else if (sof_period > 0 && cyc_n % sof_period == 0) begin
            sof_valid = 1;
        end
    endtask

    task automatic run(int n);
        repeat (n) cyc();
    endtask

    task automatic wait_pkts(int n, int budget);
        int i = 0;
        while (pkt_lens.size() < n && i < budget) begin
            cyc();
            i++;
        end
        chk("pkt_timeout", pkt_lens.size() >= n, 1);
    endtask

    task automatic check_reset(string t);
        #2;
        chk({t, "_req"}, in_ep_req, 0);
        chk({t, "_put"}, in_ep_data_put, 0);
        chk({t, "_done"}, in_ep_data_done, 0);
        chk({t, "_stall"}, in_ep_stall, 0);
        chk({t, "_data"}, in_ep_data, 0);
        chk({t, "_ready"}, in_ready, 1);
        chk({t, "_level"}, fifo_level, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        in_ep_grant = 1;
        in_ep_data_free = 1;
        check_reset("rst");

        // Max-size packet followed by exactly one ZLP
        for (int i = 0; i < 64; i++) src_q.push_back(8'(i));
        wait_pkts(1, 300);
        chk("t1_len", pkt_lens[0], 64);
        run(10);
        chk("t1_no_early_zlp", pkt_lens.size(), 1);
        sof_now = 2;
        run(20);
        chk("t1_zlp_count", pkt_lens.size(), 2);
        chk("t1_zlp_len", pkt_lens[1], 0);
        sof_now = 3;
        run(20);
        chk("t1_single_zlp", pkt_lens.size(), 2);

        // Short packet flushed only after the second SOF
        pkt_lens.delete();
        for (int i = 0; i < 5; i++) src_q.push_back(8'(8'hA1 + i));
        run(10);
        sof_now = 1;
        req_low = 0;
        repeat (20) begin
            cyc();
            if (in_ep_req) req_low++;
        end
        chk("t2_no_req_one_sof", req_low, 0);
        sof_now = 1;
        wait_pkts(1, 50);
        chk("t2_len", pkt_lens[0], 5);
        sof_now = 4;
        run(30);
        chk("t2_no_zlp", pkt_lens.size(), 1);

        // Full FIFO with grant withheld, then drain as 64/64/64/8
        pkt_lens.delete();
        grant_en = 0;
        for (int i = 0; i < 200; i++) src_q.push_back(8'($urandom));
        run(260);
        chk("t3_level_full", fifo_level, 128);
        chk("t3_ready_low", in_ready, 0);
        chk("t3_backlog", src_q.size(), 72);
        grant_en = 1;
        sof_period = 50;
        wait_pkts(4, 2000);
        sof_period = 0;
        chk("t3_pkt0", pkt_lens[0], 64);
        chk("t3_pkt1", pkt_lens[1], 64);
        chk("t3_pkt2", pkt_lens[2], 64);
        chk("t3_pkt3", pkt_lens[3], 8);
        run(10);

        // Backpressure via toggling data_free
        pkt_lens.delete();
        free_mode = 1;
        for (int i = 0; i < 64; i++) src_q.push_back(8'($urandom));
        wait_pkts(1, 500);
        chk("t4_len", pkt_lens[0], 64);
        free_mode = 0;
        run(10);

        // ACK withheld for 1000 cycles
        pkt_lens.delete();
        auto_ack = 0;
        for (int i = 0; i < 64; i++) src_q.push_back(8'($urandom));
        wait_pkts(1, 300);
        for (int i = 0; i < 10; i++) src_q.push_back(8'($urandom));
        puts0 = puts_total;
        req_low = 0;
        repeat (1000) begin
            cyc();
            if (!in_ep_req) req_low++;
        end
        chk("t5_req_held", req_low, 0);
        chk("t5_no_puts", puts_total - puts0, 0);
        chk("t5_queued", fifo_level, 10);
        ack_wait = 0;
        run(5);
        auto_ack = 1;
        sof_now = 2;
        wait_pkts(2, 100);
        chk("t5_next_len", pkt_lens[1], 10);
        run(10);
        sof_now = 3;
        run(20);
        chk("t5_no_zlp", pkt_lens.size(), 2);

        // Reset in the middle of a packet
        pkt_lens.delete();
        for (int i = 0; i < 64; i++) src_q.push_back(8'($urandom));
        k = 0;
        while (cur_len < 10 && k < 400) begin
            cyc();
            k++;
        end
        chk("t6_reach10", cur_len, 10);
        reset = 1;
        cyc();
        reset = 0;
        exp_q.delete();
        src_q.delete();
        model_level = 0;
        cur_len = 0;
        prev_len = -1;
        ack_wait = -1;
        check_reset("t6");
        for (int i = 0; i < 3; i++) src_q.push_back(8'($urandom));
        run(8);
        sof_now = 2;
        wait_pkts(1, 100);
        chk("t6_len", pkt_lens[0], 3);
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
